// File: rtl/input_conditioner_array.sv
// rtl/input_conditioner_array.sv - multi-channel synchronizer, debouncer and edge detector
// Sticky per-channel edge flags with write-1-to-clear and a masked, registered interrupt.
`timescale 1ns/1ps
module input_conditioner_array #(
    parameter int                  CHANNELS    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  WAIT_TIME   = 3,
    parameter int                  CNT_WIDTH   = 4,
    parameter logic [CHANNELS-1:0] RESET_LEVEL = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisysignal,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge,
    input  logic [CHANNELS-1:0] edge_mask,
    input  logic [CHANNELS-1:0] edge_clear,
    output logic [CHANNELS-1:0] edge_pending,
    output logic                irq
);

    localparam logic [CNT_WIDTH-1:0] WAIT_LIMIT = CNT_WIDTH'(WAIT_TIME);

    logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
    logic [CNT_WIDTH-1:0] cnt_q  [CHANNELS];
    logic [CHANNELS-1:0]  synced;
    logic [CHANNELS-1:0]  differ;
    logic [CHANNELS-1:0]  accept;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_LEVEL;
            end
        end else begin
            sync_q[0] <= noisysignal;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // A channel is accepted once it has differed for WAIT_TIME+1 consecutive cycles.
    always_comb begin
        differ = synced ^ conditioned;
        accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i] = differ[i] && (cnt_q[i] >= WAIT_LIMIT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
            conditioned  <= RESET_LEVEL;
            positiveedge <= '0;
            negativeedge <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!differ[i] || accept[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
            conditioned  <= conditioned ^ accept;
            positiveedge <= accept & synced;
            negativeedge <= accept & ~synced;
        end
    end

    // Pulses are taken from the registered edge outputs so a clear issued while a pulse is visible loses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_pending <= '0;
            irq          <= 1'b0;
        end else begin
            edge_pending <= (edge_pending & ~edge_clear) | positiveedge | negativeedge;
            irq          <= |(edge_pending & edge_mask);
        end
    end

endmodule

// File: tb/tb_input_conditioner_array.sv
// tb/tb_input_conditioner_array.sv - directed table, corner sequences and random model check
// Default-parameter instance plus a 4-channel, 3-stage, WAIT_TIME=5 instance.
`timescale 1ns/1ps
module tb_input_conditioner_array;

    logic       clk;
    logic       reset0, reset1;
    logic [7:0] noisy0, mask0, clear0, cond0, pos0, neg0, pend0;
    logic       irq0;
    logic [3:0] noisy1, mask1, clear1, cond1, pos1, neg1, pend1;
    logic       irq1;

    int checks = 0;
    int errors = 0;

    input_conditioner_array u0 (
        .clk(clk), .reset(reset0), .noisysignal(noisy0), .conditioned(cond0),
        .positiveedge(pos0), .negativeedge(neg0), .edge_mask(mask0),
        .edge_clear(clear0), .edge_pending(pend0), .irq(irq0)
    );

    input_conditioner_array #(
        .CHANNELS(4), .SYNC_STAGES(3), .WAIT_TIME(5), .CNT_WIDTH(3), .RESET_LEVEL(4'b1010)
    ) u1 (
        .clk(clk), .reset(reset1), .noisysignal(noisy1), .conditioned(cond1),
        .positiveedge(pos1), .negativeedge(neg1), .edge_mask(mask1),
        .edge_clear(clear1), .edge_pending(pend1), .irq(irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] noisy;
        logic [7:0] clr;
        logic [7:0] mask;
        int         cyc;
        logic [7:0] e_cond;
        logic [7:0] e_pos;
        logic [7:0] e_neg;
        logic [7:0] e_pend;
        logic       e_irq;
    } vec_t;

    vec_t vecs [19];

    // Reference model for the default instance: a channel flips when the last
    // WAIT_TIME+1 synchronized samples all disagree with the current level.
    localparam int MS = 2;
    localparam int MW = 3;
    logic [7:0] hist [$];
    logic [7:0] m_cond, m_pos, m_neg, m_pend;
    logic       m_irq;

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < MS + MW + 1; k++) hist.push_back(8'h00);
        m_cond = '0; m_pos = '0; m_neg = '0; m_pend = '0; m_irq = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] ns, input logic [7:0] clr, input logic [7:0] msk);
        logic [7:0] flip, n_cond, n_pend;
        logic       n_irq;
        n_pend = (m_pend & ~clr) | m_pos | m_neg;
        n_irq  = |(m_pend & msk);
        hist.push_back(ns);
        flip = '0;
        for (int i = 0; i < 8; i++) begin
            logic all_diff;
            all_diff = 1'b1;
            for (int j = 0; j <= MW; j++) begin
                logic [7:0] smp;
                smp = hist[hist.size() - 1 - MS - j];
                if (smp[i] == m_cond[i]) all_diff = 1'b0;
            end
            flip[i] = all_diff;
        end
        n_cond = m_cond ^ flip;
        m_pos  = flip & n_cond;
        m_neg  = flip & ~n_cond;
        m_cond = n_cond;
        m_pend = n_pend;
        m_irq  = n_irq;
        while (hist.size() > 12) void'(hist.pop_front());
    endtask

    initial begin
        logic seen;
        vecs[0]  = '{8'h01, 8'h00, 8'h00, 5, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{8'h01, 8'h00, 8'h00, 1, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{8'h01, 8'h00, 8'h00, 1, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0};
        vecs[3]  = '{8'h09, 8'h00, 8'h00, 5, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0};
        vecs[4]  = '{8'h09, 8'h00, 8'h00, 1, 8'h09, 8'h08, 8'h00, 8'h01, 1'b0};
        vecs[5]  = '{8'h09, 8'h08, 8'h00, 1, 8'h09, 8'h00, 8'h00, 8'h09, 1'b0};
        vecs[6]  = '{8'h09, 8'h08, 8'h00, 1, 8'h09, 8'h00, 8'h00, 8'h01, 1'b0};
        vecs[7]  = '{8'h09, 8'h01, 8'h00, 1, 8'h09, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{8'h0D, 8'h00, 8'h00, 6, 8'h0D, 8'h04, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{8'h0D, 8'h00, 8'h00, 1, 8'h0D, 8'h00, 8'h00, 8'h04, 1'b0};
        vecs[10] = '{8'h0D, 8'h04, 8'h00, 1, 8'h0D, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{8'h09, 8'h00, 8'h00, 6, 8'h09, 8'h00, 8'h04, 8'h00, 1'b0};
        vecs[12] = '{8'h09, 8'h00, 8'h00, 1, 8'h09, 8'h00, 8'h00, 8'h04, 1'b0};
        vecs[13] = '{8'h09, 8'h00, 8'h00, 3, 8'h09, 8'h00, 8'h00, 8'h04, 1'b0};
        vecs[14] = '{8'h09, 8'h04, 8'h00, 1, 8'h09, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[15] = '{8'h19, 8'h00, 8'h00, 7, 8'h19, 8'h00, 8'h00, 8'h10, 1'b0};
        vecs[16] = '{8'h19, 8'h00, 8'h10, 1, 8'h19, 8'h00, 8'h00, 8'h10, 1'b1};
        vecs[17] = '{8'h19, 8'h10, 8'h10, 1, 8'h19, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[18] = '{8'h19, 8'h00, 8'h10, 1, 8'h19, 8'h00, 8'h00, 8'h00, 1'b0};

        reset0 = 1'b1; reset1 = 1'b1;
        noisy0 = '0; mask0 = '0; clear0 = '0;
        noisy1 = 4'b1010; mask1 = '0; clear1 = '0;
        repeat (3) @(negedge clk);

        chk("reset_cond0", cond0, 8'h00);
        chk("reset_edges0", {pos0, neg0, pend0}, 24'h0);
        chk("reset_irq0", irq0, 1'b0);
        chk("reset_cond1", cond1, 4'b1010);
        chk("reset_edges1", {pos1, neg1, pend1, 3'b000, irq1}, 16'h0);

        reset0 = 1'b0; reset1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("release_edges1", {pos1, neg1}, 8'h00);
            chk("release_edges0", {pos0, neg0}, 16'h0000);
        end
        chk("release_cond1", cond1, 4'b1010);
        chk("release_pend1", pend1, 4'b0000);

        for (int v = 0; v < 19; v++) begin
            noisy0 = vecs[v].noisy; clear0 = vecs[v].clr; mask0 = vecs[v].mask;
            repeat (vecs[v].cyc) step();
            chk($sformatf("vec%0d_cond", v), cond0, vecs[v].e_cond);
            chk($sformatf("vec%0d_pos", v), pos0, vecs[v].e_pos);
            chk($sformatf("vec%0d_neg", v), neg0, vecs[v].e_neg);
            chk($sformatf("vec%0d_pend", v), pend0, vecs[v].e_pend);
            chk($sformatf("vec%0d_irq", v), irq0, vecs[v].e_irq);
        end
        clear0 = '0; mask0 = '0;

        // Glitch train on ch1, offset so toggles never coincide with a clock edge.
        seen = 1'b0;
        fork
            begin
                #0.5;
                repeat (10) #7 noisy0[1] = ~noisy0[1];
            end
            begin
                repeat (15) begin
                    @(negedge clk);
                    seen = seen | pos0[1] | neg0[1];
                end
            end
        join
        chk("glitch_edges", seen, 1'b0);
        chk("glitch_cond", cond0, 8'h19);
        chk("glitch_pend", pend0, 8'h00);

        // Reset during a count on the parameterised instance.
        noisy1 = 4'b1011;
        repeat (4) step();
        chk("midcount_cond1", cond1, 4'b1010);
        reset1 = 1'b1;
        #1;
        chk("async_reset_cond1", cond1, 4'b1010);
        step();
        reset1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("relatency_e%0d", c), {cond1, pos1}, {4'b1010, 4'b0000});
        end
        step();
        chk("relatency_e9_cond", cond1, 4'b1011);
        chk("relatency_e9_pos", pos1, 4'b0001);
        step();
        chk("p1_pend", pend1, 4'b0001);
        chk("p1_pos_off", pos1, 4'b0000);
        mask1 = 4'b0001;
        step();
        chk("p1_irq", irq1, 1'b1);

        // Randomised run against the reference model.
        noisy0 = '0; clear0 = '0; mask0 = '0;
        reset0 = 1'b1;
        step();
        reset0 = 1'b0;
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(7) == 0) noisy0[i] = ~noisy0[i];
            end
            clear0 = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(15) == 0) mask0 = 8'($urandom);
            @(posedge clk);
            model_edge(noisy0, clear0, mask0);
            @(negedge clk);
            chk("rand_cond", cond0, m_cond);
            chk("rand_pos", pos0, m_pos);
            chk("rand_neg", neg0, m_neg);
            chk("rand_pend", pend0, m_pend);
            chk("rand_irq", irq0, m_irq);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
